// File: rtl/pipeline_hazard_ctrl_if.sv
// Data-memory request/ready handshake bundle.
// master = hazard controller, slave = data memory.
interface pipeline_hazard_ctrl_if;
  logic dmem_req;
  logic dmem_ready;

  modport master (
    output dmem_req,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    output dmem_ready
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/dmem-freeze control for the 5-stage MIPS pipeline.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  IDop,
  input  logic [5:0]  EXop,
  input  logic [5:0]  MEMop,
  input  logic [4:0]  IDrs,
  input  logic [4:0]  IDrt,
  input  logic [4:0]  EXrt,
  input  logic [4:0]  EXrd,
  input  logic [4:0]  MEMrt,
  input  logic        branch_taken,
  pipeline_hazard_ctrl_if.master dmem,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_RT = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN,
    MEMWAIT,
    ERROR
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;

  logic rs_use, rt_use, is_br;
  logic ex_dv;
  logic [4:0] ex_dst;
  logic load_use, br_haz, stall;
  logic flush_req, mem_acc;
  logic freeze, req;

  always_comb begin
    rs_use = 1'b0;
    rt_use = 1'b0;
    is_br  = 1'b0;
    unique case (IDop)
      OP_RT: begin
        rs_use = 1'b1;
        rt_use = 1'b1;
      end
      OP_ADDI, OP_LW: rs_use = 1'b1;
      OP_SW: begin
        rs_use = 1'b1;
        rt_use = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        rs_use = 1'b1;
        rt_use = 1'b1;
        is_br  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_dv  = 1'b0;
    ex_dst = 5'd0;
    unique case (EXop)
      OP_RT: begin
        ex_dv  = 1'b1;
        ex_dst = EXrd;
      end
      OP_ADDI, OP_LW: begin
        ex_dv  = 1'b1;
        ex_dst = EXrt;
      end
      default: ;
    endcase
  end

  // $zero is never a real dependency.
  always_comb begin
    load_use = (EXop == OP_LW) &&
               (EXrt != 5'd0) &&
               ((rs_use && IDrs == EXrt) ||
                (rt_use && IDrt == EXrt));
    br_haz = is_br &&
             ((ex_dv && ex_dst != 5'd0 &&
               (ex_dst == IDrs ||
                ex_dst == IDrt)) ||
              (MEMop == OP_LW &&
               MEMrt != 5'd0 &&
               (MEMrt == IDrs ||
                MEMrt == IDrt)));
    stall = load_use || br_haz;
    flush_req = (IDop == OP_J) ||
                (is_br && branch_taken);
    mem_acc = (MEMop == OP_LW) ||
              (MEMop == OP_SW);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    freeze      = 1'b0;
    req         = 1'b0;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_acc) begin
          req = 1'b1;
          if (!dmem.dmem_ready) begin
            freeze  = 1'b1;
            state_d = MEMWAIT;
            cnt_d   = '0;
          end
        end
      end
      MEMWAIT: begin
        req = 1'b1;
        // Ready wins over the timeout.
        if (dmem.dmem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          freeze = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_d == TMO) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ERROR: freeze = 1'b1;
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else if (stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else if (flush_req) begin
      ifid_flush = 1'b1;
    end

    if (reset) begin
      state_d     = RUN;
      cnt_d       = '0;
      err_d       = 1'b0;
      freeze      = 1'b0;
      req         = 1'b0;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    err_q   <= err_d;
  end

  assign pipe_freeze   = freeze;
  assign dmem.dmem_req = req;
  assign mem_err       = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_we)
        stall_cnt_d = stall_cnt_q + 32'd1;
      if (ifid_flush)
        flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Ctl vector: {pc_we,ifid_we,flush,bubble,freeze,req}.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] NOP = 6'b111111;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [5:0] IDop, EXop, MEMop;
  logic [4:0] IDrs, IDrt, EXrt, EXrd, MEMrt;
  logic branch_taken;
  logic pc_we, ifid_we, ifid_flush;
  logic idex_bubble, pipe_freeze, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad = 0;

  pipeline_hazard_ctrl_if dmem ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .IDop(IDop),
    .EXop(EXop),
    .MEMop(MEMop),
    .IDrs(IDrs),
    .IDrt(IDrt),
    .EXrt(EXrt),
    .EXrd(EXrd),
    .MEMrt(MEMrt),
    .branch_taken(branch_taken),
    .dmem(dmem.master),
    .pc_we(pc_we),
    .ifid_we(ifid_we),
    .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .pipe_freeze(pipe_freeze),
    .mem_err(mem_err),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IDop = NOP;
    EXop = NOP;
    MEMop = NOP;
    IDrs = 5'd0;
    IDrt = 5'd0;
    EXrt = 5'd0;
    EXrd = 5'd0;
    MEMrt = 5'd0;
    branch_taken = 1'b0;
    dmem.dmem_ready = 1'b0;
  endtask

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic ctl(
    input string tag,
    input logic [5:0] exp
  );
    #2;
    chk(tag, {26'd0, pc_we, ifid_we,
              ifid_flush, idex_bubble,
              pipe_freeze, dmem.dmem_req},
        {26'd0, exp});
  endtask

  function automatic logic [31:0] pc(
    input int n
  );
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    MEMop = LW;
    cyc();
    ctl("rst_ctl", 6'b001100);
    chk("rst_err", {31'd0, mem_err}, 0);

    cyc();
    reset = 1'b0;
    idle();
    ctl("idle", 6'b110000);
    chk("idle_scnt", stall_cnt, 0);
    chk("idle_fcnt", flush_cnt, 0);

    // load-use
    cyc();
    EXop = LW; EXrt = 5'd5;
    IDop = RT; IDrs = 5'd1; IDrt = 5'd5;
    ctl("lu_stall", 6'b000100);
    cyc();
    EXop = NOP;
    ctl("lu_release", 6'b110000);

    // LW feeding BEQ: two stalls
    cyc();
    IDop = BEQ; IDrs = 5'd8; IDrt = 5'd2;
    EXop = LW; EXrt = 5'd8;
    ctl("br_ex", 6'b000100);
    cyc();
    EXop = NOP;
    MEMop = LW; MEMrt = 5'd8;
    dmem.dmem_ready = 1'b1;
    ctl("br_mem", 6'b000101);
    cyc();
    MEMop = NOP;
    dmem.dmem_ready = 1'b0;
    ctl("br_go", 6'b110000);
    chk("scnt3", stall_cnt, pc(3));

    // taken BNE, no hazard
    cyc();
    IDop = BNE; IDrs = 5'd3; IDrt = 5'd4;
    branch_taken = 1'b1;
    EXop = RT; EXrd = 5'd7;
    ctl("bne_flush", 6'b111000);
    cyc();
    IDop = NOP; branch_taken = 1'b0;
    ctl("bne_once", 6'b110000);
    // $zero never matches
    cyc();
    IDop = BNE; IDrs = 5'd0; IDrt = 5'd4;
    branch_taken = 1'b1;
    EXop = RT; EXrd = 5'd0;
    ctl("r0_nostall", 6'b111000);
    cyc();
    IDop = JMP; branch_taken = 1'b0;
    EXop = NOP;
    ctl("jmp", 6'b111000);
    // stalled branch is not flushed
    cyc();
    IDop = BEQ; IDrs = 5'd9;
    branch_taken = 1'b1;
    EXop = ADDI; EXrt = 5'd9;
    ctl("br_nof", 6'b000100);
    chk("fcnt3", flush_cnt, pc(3));

    // SW, ready on 3rd MEMWAIT cycle
    cyc();
    idle();
    IDop = JMP;
    MEMop = SW;
    ctl("sw_run", 6'b000011);
    cyc();
    ctl("sw_w1", 6'b000011);
    cyc();
    ctl("sw_w2", 6'b000011);
    cyc();
    IDop = NOP;
    dmem.dmem_ready = 1'b1;
    ctl("sw_w3", 6'b110001);
    cyc();
    idle();
    ctl("sw_done", 6'b110000);

    // ready on the timeout cycle wins
    cyc();
    MEMop = SW;
    ctl("tw_run", 6'b000011);
    cyc();
    cyc();
    cyc();
    ctl("tw_w3", 6'b000011);
    cyc();
    dmem.dmem_ready = 1'b1;
    ctl("tw_w4", 6'b110001);
    cyc();
    idle();
    ctl("tw_done", 6'b110000);
    chk("tw_err", {31'd0, mem_err}, 0);

    // timeout to ERROR
    cyc();
    MEMop = LW;
    ctl("to_run", 6'b000011);
    cyc();
    cyc();
    cyc();
    cyc();
    ctl("to_w4", 6'b000011);
    chk("to_w4_err", {31'd0, mem_err}, 0);
    cyc();
    ctl("to_error", 6'b000010);
    chk("to_err", {31'd0, mem_err}, 1);
    cyc();
    reset = 1'b1;
    ctl("to_rst", 6'b001100);
    cyc();
    reset = 1'b0;
    idle();
    ctl("to_back", 6'b110000);
    chk("to_clr", {31'd0, mem_err}, 0);

    // reset mid-MEMWAIT
    cyc();
    MEMop = LW;
    ctl("mw_run", 6'b000011);
    cyc();
    ctl("mw_w1", 6'b000011);
    cyc();
    reset = 1'b1;
    ctl("mw_rst", 6'b001100);
    cyc();
    reset = 1'b0;
    MEMop = NOP;
    ctl("mw_after", 6'b110000);
    chk("mw_scnt", stall_cnt, 0);
    chk("mw_fcnt", flush_cnt, 0);
    chk("mw_err", {31'd0, mem_err}, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall, flush and data-memory sequencing controller for the 5-stage pipelined MIPS CPU. It consumes the ID/EX/MEM opcode and register fields that also feed the forwarding detectors, and drives the pipeline-register write enables, bubble and flush controls. It also runs a request/ready handshake with a multi-cycle data memory, freezing the whole pipeline while a MEM-stage LW or SW is outstanding. It sits in the top-level CPU beside the forwarding units.

## Interface
- MEM_TIMEOUT, 15: maximum MEMWAIT cycles before an error is declared; legal range 1..255.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- IDop, EXop, MEMop  in  6 each  opcodes in ID, EX and MEM.
- IDrs, IDrt  in  5 each  source registers in ID.
- EXrt, EXrd  in  5 each  candidate destination registers in EX.
- branch_taken  in  1  ID-stage comparator result; meaningful only for BEQ/BNE.
- dmem_ready  in  1  data memory has completed the current access.
- pc_we, ifid_we  out  1 each  PC and IF/ID write enables.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP.
- pipe_freeze  out  1  hold EX/MEM and MEM/WB; ID/EX also held.
- dmem_req  out  1  data-memory access request.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

## Operation
- Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, BNE=000101, J=000010, ADDI=001000.
- Destination of a stage: RTYPE uses rd. ADDI and LW use rt. Any other opcode has no destination. Register 0 never matches.
- ID reads rs for RTYPE, ADDI, LW, SW, BEQ and BNE. ID reads rt for RTYPE, SW, BEQ and BNE.
- Load-use hazard: EXop=LW and EXrt matches a register that ID reads.
- Branch hazard: IDop is BEQ or BNE and one of the following holds:
  - the EX destination (RTYPE/ADDI/LW) matches IDrs or IDrt;
  - MEMop=LW and MEMrt matches IDrs or IDrt.
- Hazard stall: pc_we=0, ifid_we=0, idex_bubble=1. Hazards are re-evaluated every cycle. As a result, LW in EX feeding a branch stalls 2 cycles.
- Flush: in a non-stalled RUN cycle, ifid_flush=1 when IDop=J, or when IDop is BEQ/BNE and branch_taken=1.
- FSM states are RUN, MEMWAIT and ERROR.
  - RUN: if MEMop is LW or SW, dmem_req=1. If dmem_ready=1 in the same cycle, there is no freeze. Otherwise pipe_freeze=1, pc_we=0, ifid_we=0, and the FSM moves to MEMWAIT with the wait counter cleared.
  - MEMWAIT: dmem_req=1, pipe_freeze=1, pc_we=0, ifid_we=0, idex_bubble=0 and ifid_flush=0; the wait counter increments.
    - If dmem_ready=1: the freeze is released in that same cycle and the FSM returns to RUN. The pipeline advances on that edge, so the access is not re-requested.
    - Else if the wait count reaches MEM_TIMEOUT: go to ERROR.
  - ERROR: mem_err=1, pipe_freeze=1, pc_we=0, ifid_we=0, dmem_req=0. The FSM leaves ERROR only on reset.
- Priority is freeze/ERROR, then hazard stall, then flush. A flush is suppressed while stalled or frozen; the branch stays in ID and is re-evaluated.

## Timing
- Hazard, flush and freeze outputs are combinational from inputs and state, so they take effect on the same edge (zero latency).
- State, wait counter, mem_err and performance counters are registered.
- While reset=1: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0, dmem_req=0.
- On reset: the FSM enters RUN, the wait counter, mem_err and all counters clear. Reset during MEMWAIT or ERROR abandons the access.
- Wait counter width is ceil(log2(MEM_TIMEOUT+1)). dmem_ready arriving on the same cycle the count reaches MEM_TIMEOUT wins, and the FSM returns to RUN.
- Minimum access cost: 0 extra cycles if dmem_ready is high in the RUN cycle; otherwise N extra cycles, where dmem_ready arrives in MEMWAIT cycle N.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments by 1 every cycle in which pc_we=0 and reset=0;
  - flush_cnt increments by 1 every cycle in which ifid_flush=1 and reset=0;
  - both wrap modulo 2^32.
- HAZARD_PERF_CNT_EN undefined: no counter registers are built, and stall_cnt and flush_cnt are constant 0.

## Test plan
- EXop=LW, EXrt=5, IDop=RTYPE, IDrt=5 -> pc_we=0, ifid_we=0, idex_bubble=1 for exactly 1 cycle.
- IDop=BEQ, IDrs=8, EXop=LW, EXrt=8, then the LW advances to MEM -> stall for 2 consecutive cycles; with HAZARD_PERF_CNT_EN, stall_cnt=2.
- IDop=BNE, branch_taken=1, no hazard -> ifid_flush=1 for 1 cycle. The same setup with IDrs=0 matching an EX RTYPE with rd=0 -> no stall.
- MEMop=SW, dmem_ready rises on the 3rd MEMWAIT cycle -> pipe_freeze=1 for 3 cycles, dmem_req=1 throughout, then RUN.
- MEMop=LW, MEM_TIMEOUT=4, dmem_ready held 0 -> ERROR after 4 MEMWAIT cycles with mem_err=1 and dmem_req=0. Asserting reset for 1 cycle returns to RUN with mem_err=0.
- Reset asserted mid-MEMWAIT -> next cycle state is RUN, dmem_req=0 if MEMop is not LW/SW, and counters are 0.
